// File: rtl/vx_lsu_req_arb.sv
// vx_lsu_req_arb: round-robin arbiter that funnels NUM_REQS LSU request
// streams into one registered request port toward the LSU.
module vx_lsu_req_arb #(
    parameter  int NUM_REQS   = 4,
    parameter  int DATA_WIDTH = 256,
    localparam int SEL_BITS   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [NUM_REQS-1:0]            req_valid_i,
    input  logic [NUM_REQS*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQS-1:0]            req_ready_o,
    output logic                           out_valid_o,
    output logic [DATA_WIDTH-1:0]          out_data_o,
    output logic [SEL_BITS-1:0]            out_sel_o,
    input  logic                           out_ready_i,
    output logic [15:0]                    grant_count_o
);

    // (base + off) mod NUM_REQS; one extra bit holds the sum before folding
    function automatic logic [SEL_BITS-1:0] rr_index(input logic [SEL_BITS-1:0] base,
                                                     input logic [SEL_BITS-1:0] off);
        logic [SEL_BITS:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= (SEL_BITS+1)'(NUM_REQS))
            s = s - (SEL_BITS+1)'(NUM_REQS);
        return s[SEL_BITS-1:0];
    endfunction

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_BITS-1:0]   out_sel_q,   out_sel_d;
    logic [SEL_BITS-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [15:0]           count_q,     count_d;

    logic                  stage_free;
    logic                  win_found;
    logic [SEL_BITS-1:0]   win_idx;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  accept;

    assign stage_free = !out_valid_q || out_ready_i;

    // Round-robin search starting at rr_ptr; walking downward lets the
    // closest valid requester to the pointer overwrite the farther ones.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NUM_REQS-1; k >= 0; k--) begin
            if (req_valid_i[rr_index(rr_ptr_q, SEL_BITS'(k))]) begin
                win_found = 1'b1;
                win_idx   = rr_index(rr_ptr_q, SEL_BITS'(k));
            end
        end
    end

    // Payload mux of the winner and the one-hot grant back to requesters
    always_comb begin
        win_data    = '0;
        req_ready_o = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (win_idx == SEL_BITS'(i))
                win_data = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            req_ready_o[i] = win_found && stage_free && !reset_i && (win_idx == SEL_BITS'(i));
        end
    end

    assign accept = win_found && stage_free;

    // Next state of the output stage, pointer and grant counter
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        rr_ptr_d    = rr_ptr_q;
        count_d     = count_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = win_data;
            out_sel_d   = win_idx;
            rr_ptr_d    = (win_idx == SEL_BITS'(NUM_REQS-1)) ? '0 : win_idx + 1'b1;
            count_d     = count_q + 16'd1;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset drops any pending output request
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            rr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            rr_ptr_q    <= rr_ptr_d;
            count_q     <= count_d;
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_data_o    = out_data_q;
    assign out_sel_o     = out_sel_q;
    assign grant_count_o = count_q;

endmodule

// File: tb/tb_vx_lsu_req_arb.sv
// Bench for vx_lsu_req_arb: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_vx_lsu_req_arb;
    localparam int N  = 4;
    localparam int DW = 256;
    localparam int SB = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [DW-1:0]     rd [N];
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [SB-1:0]     out_sel;
    logic              out_ready = 1'b0;
    logic [15:0]       grant_count;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;
    logic [N-1:0] last_acc;

    // model state
    bit            m_valid = 0;
    logic [DW-1:0] m_data = '0;
    int            m_sel = 0;
    int            m_rr = 0;
    int            m_cnt = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = rd[i];
    end

    vx_lsu_req_arb #(.NUM_REQS(N), .DATA_WIDTH(DW)) dut (
        .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_data_i(req_data),
        .req_ready_o(req_ready), .out_valid_o(out_valid), .out_data_o(out_data),
        .out_sel_o(out_sel), .out_ready_i(out_ready), .grant_count_o(grant_count));

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // first valid requester at or after the pointer, -1 if none
    function automatic int model_winner();
        for (int k = 0; k < N; k++)
            if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        int w;
        r = '0;
        w = model_winner();
        if (!reset && w >= 0 && (!m_valid || out_ready)) r[w] = 1'b1;
        return r;
    endfunction

    // model advances on each rising edge from the inputs held during the cycle
    always @(posedge clk) begin
        int w;
        if (reset) begin
            m_valid = 0; m_data = '0; m_sel = 0; m_rr = 0; m_cnt = 0;
        end else begin
            w = model_winner();
            if (w >= 0 && (!m_valid || out_ready)) begin
                m_valid = 1; m_data = rd[w]; m_sel = w;
                m_rr = (w + 1) % N; m_cnt = (m_cnt + 1) % 65536;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
        end
    end

    // compare process: every cycle, away from the clock edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", DW'(req_ready), DW'(model_ready()));
            chk("out_valid", DW'(out_valid), DW'(m_valid));
            chk("grant_count", DW'(grant_count), DW'(m_cnt));
            if (m_valid) begin
                chk("out_sel", DW'(out_sel), DW'(m_sel));
                chk("out_data", out_data, m_data);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        last_acc = req_valid & req_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_word(output logic [DW-1:0] w);
        for (int j = 0; j < DW/32; j++) w[j*32 +: 32] = $urandom;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) rd[i] = '0;
        tick(); tick();
        chk_en = 1'b1;
        reset = 1'b0;

        // idle after reset
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_valid", DW'(out_valid), DW'(0));
            chk("idle_ready", DW'(req_ready), DW'(0));
            chk("idle_count", DW'(grant_count), DW'(0));
            chk("idle_sel", DW'(out_sel), DW'(0));
        end

        // single requester 2
        out_ready = 1'b1;
        rd[2] = 256'hA5;
        req_valid = 4'b0100;
        #1;
        chk("single_ready", DW'(req_ready), DW'(4'b0100));
        tick();
        req_valid = '0;
        chk("single_valid", DW'(out_valid), DW'(1));
        chk("single_data", out_data, 256'hA5);
        chk("single_sel", DW'(out_sel), DW'(2));
        chk("single_count", DW'(grant_count), DW'(1));

        // all four continuously valid: back-to-back rotation
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) rand_word(rd[i]);
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("rot_valid", DW'(out_valid), DW'(1));
            chk("rot_sel", DW'(out_sel), DW'(c % 4));
            for (int i = 0; i < N; i++) if (last_acc[i]) rand_word(rd[i]);
        end
        chk("rot_count", DW'(grant_count), DW'(8));
        req_valid = '0;

        // pointer wrap: req 0 granted (rr=1), then 0 and 3 compete
        do_reset();
        rd[0] = 256'h100;
        req_valid = 4'b0001;
        tick();
        chk("wrap_first", DW'(out_sel), DW'(0));
        rd[0] = 256'h200; rd[3] = 256'h300;
        req_valid = 4'b1001;
        tick();
        chk("wrap_sel3", DW'(out_sel), DW'(3));
        chk("wrap_data3", out_data, 256'h300);
        req_valid = 4'b0001;
        tick();
        chk("wrap_sel0", DW'(out_sel), DW'(0));
        chk("wrap_data0", out_data, 256'h200);
        req_valid = '0;

        // output stall with req 2 waiting
        do_reset();
        rd[1] = 256'h11;
        req_valid = 4'b0010;
        tick();
        rd[2] = 256'h22;
        req_valid = 4'b0100;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall_ready", DW'(req_ready), DW'(0));
            tick();
            chk("stall_sel", DW'(out_sel), DW'(1));
            chk("stall_data", out_data, 256'h11);
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_ready", DW'(req_ready), DW'(4'b0100));
        tick();
        chk("unstall_sel", DW'(out_sel), DW'(2));
        req_valid = '0;

        // reset while the output is stalled
        out_ready = 1'b0;
        tick();
        reset = 1'b1;
        req_valid = '0;
        tick();
        chk("rst_valid", DW'(out_valid), DW'(0));
        chk("rst_count", DW'(grant_count), DW'(0));
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        rd[1] = 256'h55; rd[3] = 256'h77;
        req_valid = 4'b1010;
        tick();
        chk("post_rst_sel", DW'(out_sel), DW'(1));
        req_valid = 4'b1000;
        tick();
        req_valid = '0;

        // randomized traffic; model checks every cycle
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) if (last_acc[i]) req_valid[i] = 1'b0;
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                req_valid = '0;
            end else begin
                reset = 1'b0;
                for (int i = 0; i < N; i++)
                    if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                        rand_word(rd[i]);
                        req_valid[i] = 1'b1;
                    end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        reset = 1'b0;
        req_valid = '0;
        tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
